// File: rtl/edge_counter_mc_pkg.sv
// Shared definitions for the multi-channel edge counter: edge-mode encodings,
// parameter limits and the edge-select helper.
package edge_counter_mc_pkg;

  localparam int unsigned CH_MIN = 1;
  localparam int unsigned CH_MAX = 16;
  localparam int unsigned CW_MIN = 4;
  localparam int unsigned CW_MAX = 32;

  typedef enum logic [1:0] {
    EM_RISE = 2'b00,
    EM_FALL = 2'b01,
    EM_BOTH = 2'b10
  } edge_mode_e;

  // Mode 2'b11 is treated the same as EM_BOTH.
  function automatic logic edge_select(input logic [1:0] mode, input logic rise,
                                       input logic fall);
    logic sel;
    if (mode == EM_RISE) sel = rise;
    else if (mode == EM_FALL) sel = fall;
    else sel = rise | fall;
    return sel;
  endfunction

endpackage

// File: rtl/edge_sync_det.sv
// One channel: synchroniser chain, history flop and edge-type select.
// edge_c is a combinational single-cycle pulse off the history comparison.
module edge_sync_det
  import edge_counter_mc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       sig,
  input  logic [1:0] edge_mode,
  output logic       edge_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   rise_c;
  logic                   fall_c;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync[SYNC_STAGES-1] & ~hist;
  assign fall_c = ~sync[SYNC_STAGES-1] & hist;
  assign edge_c = edge_select(edge_mode, rise_c, fall_c);

endmodule

// File: rtl/edge_counter_mc.sv
// Multi-channel gated edge counter with saturating counters, a snapshot result
// bank and a valid/ready read handshake with sticky overrun detection.
module edge_counter_mc
  import edge_counter_mc_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned CW          = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic [CH-1:0]  sig_in,
  input  logic [CH-1:0]  ch_en,
  input  logic [1:0]     edge_mode,
  input  logic           gate_in,
  output logic [CH*CW-1:0] data_out,
  output logic [CH-1:0]  ovf_out,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic           overrun
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  if (CH < CH_MIN || CH > CH_MAX || CW < CW_MIN || CW > CW_MAX) begin : g_bad_param
    $error("edge_counter_mc: CH or CW out of range");
  end

  logic [CH-1:0]         edge_c;
  logic [CH-1:0]         hit_c;
  logic [CH-1:0][CW-1:0] cnt;
  logic [CH-1:0]         sat;
  logic                  g_d;
  logic                  latch_c;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    edge_sync_det #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
      .clk_in   (clk_in),
      .reset    (reset),
      .sig      (sig_in[i]),
      .edge_mode(edge_mode),
      .edge_c   (edge_c[i])
    );
  end

  assign hit_c = edge_c & ch_en;

  // Gate rising-edge detector; a held-high gate yields one latch.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) g_d <= 1'b0;
    else        g_d <= gate_in;
  end

  assign latch_c = gate_in & ~g_d;

  // Per-channel saturating counters; an edge on the latch cycle opens the new window.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sat <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (latch_c) begin
          cnt[i] <= CW'(hit_c[i]);
          sat[i] <= 1'b0;
        end else if (hit_c[i]) begin
          if (cnt[i] == CNT_MAX) sat[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Result bank and handshake; newest window overwrites unread data.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      ovf_out  <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (latch_c) begin
      data_out <= cnt;
      ovf_out  <= sat;
      rd_valid <= 1'b1;
      if (rd_valid && !rd_ready) overrun <= 1'b1;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_counter_mc.sv
// Self-checking bench for edge_counter_mc (CH=4, CW=8, SYNC_STAGES=2):
// directed vector table, hand-written corner sequences and a randomised run
// against a sample-history reference model.
module tb_edge_counter_mc;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 8;

  logic            clk_in = 1'b0;
  logic            reset;
  logic [CH-1:0]   sig_in;
  logic [CH-1:0]   ch_en;
  logic [1:0]      edge_mode;
  logic            gate_in;
  logic [CH*CW-1:0] data_out;
  logic [CH-1:0]   ovf_out;
  logic            rd_valid;
  logic            rd_ready;
  logic            overrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  edge_counter_mc #(.CH(CH), .CW(CW), .SYNC_STAGES(2)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .sig_in   (sig_in),
    .ch_en    (ch_en),
    .edge_mode(edge_mode),
    .gate_in  (gate_in),
    .data_out (data_out),
    .ovf_out  (ovf_out),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .overrun  (overrun)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a transition sampled at clock n is counted at clock n+2.
  int          m_cnt [CH];
  bit          m_sat [CH];
  bit          m_smp [CH][3];
  bit          m_gprev;
  logic [31:0] m_data;
  logic [3:0]  m_ovf;
  bit          m_valid;
  bit          m_ovr;

  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0;
        m_sat[i] = 0;
        for (int k = 0; k < 3; k++) m_smp[i][k] = 0;
      end
      m_gprev = 0;
      m_data  = '0;
      m_ovf   = '0;
      m_valid = 0;
      m_ovr   = 0;
    end else begin
      bit latch;
      latch = gate_in && !m_gprev;
      for (int i = 0; i < CH; i++) begin
        bit rise, fall, ev;
        rise = m_smp[i][1] && !m_smp[i][2];
        fall = !m_smp[i][1] && m_smp[i][2];
        ev   = (edge_mode == 2'b00) ? rise : (edge_mode == 2'b01) ? fall : (rise || fall);
        ev   = ev && ch_en[i];
        if (latch) begin
          m_data[i*8 +: 8] = 8'(m_cnt[i]);
          m_ovf[i]         = m_sat[i];
          m_cnt[i]         = ev ? 1 : 0;
          m_sat[i]         = 0;
        end else if (ev) begin
          if (m_cnt[i] == 255) m_sat[i] = 1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
        m_smp[i][2] = m_smp[i][1];
        m_smp[i][1] = m_smp[i][0];
        m_smp[i][0] = sig_in[i];
      end
      if (latch) begin
        if (m_valid && !rd_ready) m_ovr = 1;
        m_valid = 1;
      end else if (m_valid && rd_ready) begin
        m_valid = 0;
      end
      m_gprev = gate_in;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse(input int ch, input int periods);
    for (int p = 0; p < periods; p++) begin
      sig_in[ch] = 1'b1;
      repeat (2) @(negedge clk_in);
      sig_in[ch] = 1'b0;
      repeat (2) @(negedge clk_in);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk_in);
  endtask

  // Ends on the negedge right after the latching clock.
  task automatic do_gate();
    gate_in = 1'b1;
    @(negedge clk_in);
    gate_in = 1'b0;
  endtask

  typedef struct {
    int         ch;
    logic [1:0] mode;
    int         periods;
    logic [7:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [31:0] eb;
    logic [3:0]  eo;

    vt[0] = '{ch: 0, mode: 2'b00, periods: 10,  exp_cnt: 8'd10,  exp_ovf: 1'b0};
    vt[1] = '{ch: 0, mode: 2'b10, periods: 10,  exp_cnt: 8'd20,  exp_ovf: 1'b0};
    vt[2] = '{ch: 1, mode: 2'b01, periods: 7,   exp_cnt: 8'd7,   exp_ovf: 1'b0};
    vt[3] = '{ch: 3, mode: 2'b11, periods: 3,   exp_cnt: 8'd6,   exp_ovf: 1'b0};
    vt[4] = '{ch: 2, mode: 2'b00, periods: 300, exp_cnt: 8'd255, exp_ovf: 1'b1};
    vt[5] = '{ch: 2, mode: 2'b00, periods: 5,   exp_cnt: 8'd5,   exp_ovf: 1'b0};

    reset     = 1'b0;
    sig_in    = '0;
    ch_en     = '1;
    edge_mode = 2'b00;
    gate_in   = 1'b0;
    rd_ready  = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    settle();
    check("reset_data", 64'(data_out), 64'd0);
    check("reset_ovf", 64'(ovf_out), 64'd0);
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);

    // Table: one window per entry, single active channel.
    for (int v = 0; v < 6; v++) begin
      edge_mode = vt[v].mode;
      pulse(vt[v].ch, vt[v].periods);
      settle();
      do_gate();
      eb = '0;
      eb[vt[v].ch*8 +: 8] = vt[v].exp_cnt;
      eo = '0;
      eo[vt[v].ch] = vt[v].exp_ovf;
      check($sformatf("vec%0d_data", v), 64'(data_out), 64'(eb));
      check($sformatf("vec%0d_ovf", v), 64'(ovf_out), 64'(eo));
      check($sformatf("vec%0d_valid", v), 64'(rd_valid), 64'd1);
      @(negedge clk_in);
      check($sformatf("vec%0d_valid_fall", v), 64'(rd_valid), 64'd0);
      check($sformatf("vec%0d_hold", v), 64'(data_out), 64'(eb));
    end

    // Edge on ch3 coincident with the latch belongs to the next window.
    edge_mode  = 2'b00;
    sig_in[3]  = 1'b1;
    repeat (2) @(negedge clk_in);
    do_gate();
    check("coin_old_data", 64'(data_out), 64'd0);
    sig_in[3] = 1'b0;
    repeat (2) @(negedge clk_in);
    pulse(3, 4);
    settle();
    do_gate();
    check("coin_new_data", 64'(data_out), 64'h0500_0000);

    // Overrun: two windows with no reader.
    @(negedge clk_in);
    rd_ready = 1'b0;
    pulse(0, 3);
    settle();
    do_gate();
    check("ovr_w1_data", 64'(data_out), 64'd3);
    check("ovr_w1_overrun", 64'(overrun), 64'd0);
    pulse(0, 6);
    settle();
    do_gate();
    check("ovr_w2_data", 64'(data_out), 64'd6);
    check("ovr_w2_valid", 64'(rd_valid), 64'd1);
    check("ovr_w2_overrun", 64'(overrun), 64'd1);
    rd_ready = 1'b1;
    @(negedge clk_in);
    check("ovr_read_valid", 64'(rd_valid), 64'd0);
    repeat (5) @(negedge clk_in);
    check("ovr_sticky", 64'(overrun), 64'd1);
    check("ovr_hold_data", 64'(data_out), 64'd6);

    // Frozen channel: ch_en drops mid-window, partial count still reported.
    pulse(1, 4);
    settle();
    ch_en[1] = 1'b0;
    pulse(1, 3);
    settle();
    do_gate();
    check("freeze_data", 64'(data_out), 64'h0000_0400);
    ch_en[1] = 1'b1;

    // Reset mid-window discards the partial count and clears overrun.
    pulse(0, 3);
    reset = 1'b0;
    @(negedge clk_in);
    check("midrst_valid", 64'(rd_valid), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);
    check("midrst_data", 64'(data_out), 64'd0);
    reset = 1'b1;
    settle();
    do_gate();
    check("midrst_next_data", 64'(data_out), 64'd0);
    check("midrst_next_valid", 64'(rd_valid), 64'd1);

    // Randomised run compared against the model every cycle.
    chk_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_in);
      check("rnd_data", 64'(data_out), 64'(m_data));
      check("rnd_ovf", 64'(ovf_out), 64'(m_ovf));
      check("rnd_valid", 64'(rd_valid), 64'(m_valid));
      check("rnd_overrun", 64'(overrun), 64'(m_ovr));
      for (int i = 0; i < CH; i++)
        if ($urandom_range(3) == 0) sig_in[i] = ~sig_in[i];
      if ($urandom_range(15) == 0) ch_en = 4'($urandom);
      if ($urandom_range(31) == 0) edge_mode = 2'($urandom);
      gate_in  = ($urandom_range(9) == 0);
      rd_ready = 1'($urandom);
      reset    = (c == 1500) ? 1'b0 : 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
